// File: rtl/rename_free_list.sv
// Register-rename controller: speculative/retirement maps plus a circular
// free list of physical tags, with flush rollback to retirement state.
module rename_free_list #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned FL_DEPTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(ARCH_REGS)-1:0] i_rs_addr,
  input  logic [$clog2(ARCH_REGS)-1:0] i_rt_addr,
  output logic [TAG_WIDTH-1:0]         o_rs_tag,
  output logic [TAG_WIDTH-1:0]         o_rt_tag,
  input  logic                         i_alloc_valid,
  input  logic [$clog2(ARCH_REGS)-1:0] i_alloc_rd,
  output logic                         o_alloc_ready,
  output logic [TAG_WIDTH-1:0]         o_alloc_tag,
  output logic [TAG_WIDTH-1:0]         o_alloc_old_tag,
  input  logic                         i_commit_valid,
  input  logic [$clog2(ARCH_REGS)-1:0] i_commit_rd,
  input  logic [TAG_WIDTH-1:0]         i_commit_tag,
  input  logic                         i_flush
);

  localparam int unsigned AREG_W = $clog2(ARCH_REGS);
  localparam int unsigned FP_W   = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FL_DEPTH) + 1;
  localparam int unsigned FL_BASE = PHYS_REGS - FL_DEPTH;

  logic [TAG_WIDTH-1:0] spec_map [ARCH_REGS];
  logic [TAG_WIDTH-1:0] ret_map  [ARCH_REGS];
  logic [TAG_WIDTH-1:0] ret_post [ARCH_REGS];
  logic [TAG_WIDTH-1:0] fl       [FL_DEPTH];
  logic [FP_W-1:0]      head;
  logic [FP_W-1:0]      commit_head;
  logic [FP_W-1:0]      tail;
  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     inflight_nxt;
  logic [FP_W-1:0]      commit_head_post;
  logic                 alloc_fire;
  logic                 commit_fire;
  logic                 rd_zero_req;

  assign rd_zero_req   = i_alloc_valid && (i_alloc_rd == '0);
  assign o_alloc_ready = !rst && (inflight < CNT_W'(FL_DEPTH));
  assign alloc_fire    = i_alloc_valid && o_alloc_ready && (i_alloc_rd != '0) && !i_flush;
  assign commit_fire   = i_commit_valid && (i_commit_rd != '0);

  // Lookups; during reset the identity/reset mappings are shown directly
  always_comb begin
    o_rs_tag        = spec_map[i_rs_addr];
    o_rt_tag        = spec_map[i_rt_addr];
    o_alloc_tag     = fl[head];
    o_alloc_old_tag = spec_map[i_alloc_rd];
    if (rst) begin
      o_rs_tag        = TAG_WIDTH'(i_rs_addr);
      o_rt_tag        = TAG_WIDTH'(i_rt_addr);
      o_alloc_tag     = TAG_WIDTH'(FL_BASE);
      o_alloc_old_tag = TAG_WIDTH'(i_alloc_rd);
    end else if (rd_zero_req) begin
      o_alloc_tag     = '0;
      o_alloc_old_tag = '0;
    end
  end

  // Post-commit retirement state, which a same-cycle flush restores from
  always_comb begin
    ret_post         = ret_map;
    commit_head_post = commit_head;
    if (commit_fire) begin
      ret_post[i_commit_rd] = i_commit_tag;
      commit_head_post      = commit_head + FP_W'(1);
    end
  end

  // Outstanding-rename count; flush discards all of them
  always_comb begin
    inflight_nxt = inflight + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    if (i_flush) inflight_nxt = '0;
  end

  // Map, free-list and pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= TAG_WIDTH'(i);
        ret_map[i]  <= TAG_WIDTH'(i);
      end
      for (int unsigned k = 0; k < FL_DEPTH; k++) begin
        fl[k] <= TAG_WIDTH'(FL_BASE + k);
      end
      head        <= '0;
      commit_head <= '0;
      tail        <= '0;
      inflight    <= '0;
    end else begin
      if (commit_fire) begin
        fl[tail]             <= ret_map[i_commit_rd];
        ret_map[i_commit_rd] <= i_commit_tag;
        tail                 <= tail + FP_W'(1);
      end
      commit_head <= commit_head_post;
      if (i_flush) begin
        spec_map <= ret_post;
        head     <= commit_head_post;
      end else if (alloc_fire) begin
        spec_map[i_alloc_rd] <= fl[head];
        head                 <= head + FP_W'(1);
      end
      inflight <= inflight_nxt;
    end
  end

  // Retiring with nothing in flight means the caller lost track of renames
  a_no_commit_underflow: assert property (@(posedge clk) disable iff (rst)
    commit_fire |-> (inflight != '0));

  logic [AREG_W-1:0] unused_aw;
  assign unused_aw = '0;

endmodule

// File: tb/tb_rename_free_list.sv
// Self-checking bench for rename_free_list: vector table plus scoreboard queue.
module tb_rename_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_addr, rt_addr, alloc_rd, commit_rd;
  logic [5:0] rs_tag, rt_tag, alloc_tag, alloc_old_tag, commit_tag;
  logic       alloc_valid, alloc_ready, commit_valid, flush;

  rename_free_list dut (
    .clk(clk), .rst(rst),
    .i_rs_addr(rs_addr), .i_rt_addr(rt_addr),
    .o_rs_tag(rs_tag), .o_rt_tag(rt_tag),
    .i_alloc_valid(alloc_valid), .i_alloc_rd(alloc_rd),
    .o_alloc_ready(alloc_ready), .o_alloc_tag(alloc_tag),
    .o_alloc_old_tag(alloc_old_tag),
    .i_commit_valid(commit_valid), .i_commit_rd(commit_rd),
    .i_commit_tag(commit_tag), .i_flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       av;
    logic [4:0] ard;
    logic       cv;
    logic [4:0] crd;
    logic [5:0] ctag;
    logic       fl;
    logic [5:0] ers, ert;
    logic       erdy;
    logic [5:0] etag, eold;
  } vec_t;

  typedef struct {
    int         idx;
    logic [5:0] rs, rt;
    logic       rdy;
    logic [5:0] tag, old;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input logic r, input int rs, input int rt,
                             input logic av, input int ard,
                             input logic cv, input int crd, input int ctag,
                             input logic fl, input int ers, input int ert,
                             input logic erdy, input int etag, input int eold);
    vec_t x;
    x.r = r; x.rs = 5'(rs); x.rt = 5'(rt); x.av = av; x.ard = 5'(ard);
    x.cv = cv; x.crd = 5'(crd); x.ctag = 6'(ctag); x.fl = fl;
    x.ers = 6'(ers); x.ert = 6'(ert); x.erdy = erdy;
    x.etag = 6'(etag); x.eold = 6'(eold);
    return x;
  endfunction

  task automatic cmp(input int idx, input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL v%0d %s got=%0d want=%0d", idx, nm, act, want);
    end
  endtask

  initial begin
    exp_t e;
    // reset, lookup after reset, rd=0 request
    tbl.push_back(v(1, 5, 7, 0, 0, 0, 0, 0, 0,  5, 7, 0, 32, 0));
    tbl.push_back(v(1, 5, 7, 0, 0, 0, 0, 0, 0,  5, 7, 0, 32, 0));
    tbl.push_back(v(0, 5, 0, 0, 3, 0, 0, 0, 0,  5, 0, 1, 32, 3));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0));
    // alloc rd3: same-cycle lookup sees pre-rename tag
    tbl.push_back(v(0, 3, 4, 1, 3, 0, 0, 0, 0,  3, 4, 1, 32, 3));
    tbl.push_back(v(0, 3, 4, 0, 3, 0, 0, 0, 0, 32, 4, 1, 33, 32));
    // alloc rd4, commit rd3, flush
    tbl.push_back(v(0, 4, 3, 1, 4, 0, 0, 0, 0,  4, 32, 1, 33, 4));
    tbl.push_back(v(0, 3, 4, 0, 4, 1, 3, 32, 0, 32, 33, 1, 34, 33));
    tbl.push_back(v(0, 3, 4, 0, 0, 0, 0, 0, 1, 32, 33, 1, 34, 0));
    tbl.push_back(v(0, 3, 4, 0, 0, 0, 0, 0, 0, 32, 4, 1, 33, 0));
    // commit and flush together with one rename outstanding
    tbl.push_back(v(0, 5, 5, 1, 5, 0, 0, 0, 0,  5, 5, 1, 33, 5));
    tbl.push_back(v(0, 5, 6, 0, 5, 1, 5, 33, 1, 33, 6, 1, 34, 33));
    tbl.push_back(v(0, 5, 3, 0, 5, 0, 0, 0, 0, 33, 32, 1, 34, 33));
    // fresh reset, then fill all 32 free tags
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 32, 0));
    tbl.push_back(v(0, 2, 0, 0, 0, 0, 0, 0, 0,  2, 0, 1, 32, 0));
    for (int i = 0; i < 32; i++) begin
      int rd;
      rd = (i % 31) + 1;
      tbl.push_back(v(0, rd, 0, 1, rd, 0, 0, 0, 0,
                      (i == 31) ? 32 : rd, 0, 1, 32 + i, (i == 31) ? 32 : rd));
    end
    // full: 33rd request held, commit does not unstall same cycle
    tbl.push_back(v(0, 2, 1, 1, 2, 0, 0, 0, 0, 33, 63, 0, 32, 33));
    tbl.push_back(v(0, 2, 1, 1, 2, 0, 0, 0, 0, 33, 63, 0, 32, 33));
    tbl.push_back(v(0, 2, 1, 1, 2, 1, 1, 32, 0, 33, 63, 0, 32, 33));
    tbl.push_back(v(0, 2, 1, 1, 2, 0, 0, 0, 0, 33, 63, 1,  1, 33));
    tbl.push_back(v(0, 2, 1, 0, 2, 0, 0, 0, 0,  1, 63, 0, 33, 1));
    // reset mid-operation with a commit presented
    tbl.push_back(v(1, 2, 1, 0, 0, 1, 2, 1, 0,  2, 1, 0, 32, 0));
    tbl.push_back(v(0, 2, 1, 0, 0, 0, 0, 0, 0,  2, 1, 1, 32, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
      alloc_valid = tbl[i].av; alloc_rd = tbl[i].ard;
      commit_valid = tbl[i].cv; commit_rd = tbl[i].crd; commit_tag = tbl[i].ctag;
      flush = tbl[i].fl;
      e.idx = i; e.rs = tbl[i].ers; e.rt = tbl[i].ert; e.rdy = tbl[i].erdy;
      e.tag = tbl[i].etag; e.old = tbl[i].eold;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      cmp(e.idx, "rs_tag", int'(rs_tag), int'(e.rs));
      cmp(e.idx, "rt_tag", int'(rt_tag), int'(e.rt));
      cmp(e.idx, "alloc_ready", int'(alloc_ready), int'(e.rdy));
      cmp(e.idx, "alloc_tag", int'(alloc_tag), int'(e.tag));
      cmp(e.idx, "alloc_old_tag", int'(alloc_old_tag), int'(e.old));
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
